// File: rtl/gate_truth_sweeper.sv
// Stimulus-and-capture engine for a 2-input combinational gate: sweeps all
// four input combinations, samples the gate output after a hold period for
// each, and compares the measured truth table against an expected pattern.
module gate_truth_sweeper #(
  parameter int          HOLD_CYCLES = 10,
  parameter logic [3:0]  EXPECTED    = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] table_out,
  output logic [3:0] fail_mask
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       cap, cap_n;
  logic             in0_n, in1_n, busy_n, done_n, pass_n;
  logic [3:0]       table_n, fail_n;

  // State, sweep position, capture register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      cap       <= '0;
      in0       <= 1'b0;
      in1       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= '0;
      fail_mask <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      cap       <= cap_n;
      in0       <= in0_n;
      in1       <= in1_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      table_out <= table_n;
      fail_mask <= fail_n;
    end
  end

  // Next-state and next-output logic. Outputs are registered, so the gate
  // inputs computed here are those for the combination active after the edge.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    cap_n   = cap;
    in0_n   = 1'b0;
    in1_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    table_n = table_out;
    pass_n  = pass;
    fail_n  = fail_mask;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = APPLY;
          idx_n   = '0;
          cnt_n   = '0;
          cap_n   = '0;
          busy_n  = 1'b1;
        end
      end

      APPLY: begin
        busy_n         = 1'b1;
        {in0_n, in1_n} = idx;
        if (cnt == CNT_LAST) begin
          cap_n[idx] = gate_out;
          if (idx == 2'd3) begin
            // Final sample is merged into the results on the same edge.
            state_n        = DONE;
            busy_n         = 1'b0;
            done_n         = 1'b1;
            {in0_n, in1_n} = 2'b00;
            table_n        = cap_n;
            pass_n         = (cap_n == EXPECTED);
            fail_n         = cap_n ^ EXPECTED;
          end else begin
            idx_n          = idx + 2'd1;
            cnt_n          = '0;
            {in0_n, in1_n} = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/gate_truth_sweeper.md
# gate_truth_sweeper

Synthesizable stimulus-and-capture engine that drives a 2-input combinational gate under test (NOR, AND, OR, …), sweeps all four input combinations, and samples the gate's output for each. It assembles the measured 4-entry truth table and compares it against an expected pattern, reporting pass/fail. It sits on the driving side of any BasicGates cell, so the cell can be checked in hardware (FPGA/on-chip) rather than only in a simulation bench.

## Interface
- HOLD_CYCLES, 10, cycles each input combination is held before sampling; legal range ≥1.
- EXPECTED, 4'b0001, expected truth table indexed by {in0,in1}; the default is NOR.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- gate_out  input  1  output of the gate under test; combinational from in0/in1.
- in0  output  1  gate input 0 (MSB of the combination index).
- in1  output  1  gate input 1 (LSB of the combination index).
- busy  output  1  high while a sweep is applying stimulus.
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  high when the measured table equals EXPECTED.
- table_out  output  4  measured table; bit k = gate_out for {in0,in1}=k.
- fail_mask  output  4  table_out ^ EXPECTED.

## Operation
- All outputs are registered. Reset values: in0=in1=0, busy=0, done=0, pass=0, table_out=0, fail_mask=0; state is IDLE, index=0, hold counter=0, and the capture register is cleared.
- FSM states: IDLE, APPLY, DONE.
- IDLE: drive in0=in1=0. If start=1 at a rising edge, go to APPLY with index=0 and counter=0.
- APPLY: drive {in0,in1}=index and hold busy=1. The counter runs 0..HOLD_CYCLES-1.
  - When counter==HOLD_CYCLES-1, capture gate_out into capture[index].
  - If index==3, go to DONE. Otherwise increment index and reset the counter to 0.
- DONE: drive in0=in1=0 and busy=0, and pulse done=1 for one cycle. Then return to IDLE unconditionally.
- Results registers:
  - table_out, pass and fail_mask update only on the APPLY→DONE edge.
  - The final sample is merged in on that same edge.
  - They hold their value through IDLE and the next sweep until the next APPLY→DONE edge.
- start is ignored in APPLY and DONE; there is no queuing. If start is held high, a new sweep begins on each return to IDLE.
- The counter is $clog2(HOLD_CYCLES+1) bits wide and the index is 2 bits. Neither wraps inside a sweep.
- Reset asserted mid-sweep: all state and outputs return to reset values immediately. No done pulse is produced and partial captures are discarded.
- gate_out is sampled only on capture edges. Glitches between captures are irrelevant.

## Timing
- Let E0 be the edge where start is accepted in IDLE.
- {in0,in1}=00 from E0, 01 from E0+H, 10 from E0+2H, 11 from E0+3H, where H=HOLD_CYCLES.
- Capture of combination k happens at edge E0+(k+1)·H. The DUT therefore gets H-1 full cycles plus the same-edge settle time before sampling.
- busy is high from E0 to E0+4H. done is high from E0+4H to E0+4H+1. Results are valid from E0+4H.
- IDLE is re-entered at E0+4H+1. The earliest next accepted start is at E0+4H+2, so back-to-back sweeps have a period of 4H+2 cycles.
- With H=1: done is high in the cycle after edge E0+4, so total latency is 5 cycles.

## Test plan
- NOR DUT, defaults, 1-cycle start pulse:
  - in0/in1 step 00,01,10,11 every 10 cycles.
  - done pulses once, 40 cycles after acceptance.
  - table_out=0001, pass=1, fail_mask=0000.
- OR DUT with EXPECTED=0001: table_out=1110, pass=0, fail_mask=1111. Results hold after done until the next sweep completes.
- start pulsed at cycles 5 and 25 of a sweep: no effect. Exactly one done pulse, with timing identical to the single-start case.
- rst_n low at cycle 15 of a sweep:
  - All outputs go to 0 asynchronously and no done follows.
  - A fresh start then completes normally with pass=1.
- HOLD_CYCLES=1, NOR DUT:
  - Combinations change on every edge.
  - done is high in the cycle after edge E0+4 (5 cycles total).
  - table_out=0001.
- start held high continuously with H=10: done pulses every 42 cycles, and in0/in1=00 during each DONE/IDLE gap.
